// File: rtl/vec_sub_pipe_if.sv
// Operand-issue and writeback handshake bundle for the pipelined vector subtractor.
// No logic and no latency of its own; it only carries signals.
// Back-pressure is carried on ready_o (toward issue) and ready_i (from writeback).
interface vec_sub_pipe_if #(
  parameter int BITS = 48
);
  logic            valid_i;
  logic            ready_o;
  logic [BITS-1:0] a_i;
  logic [BITS-1:0] b_i;
  logic            bin_i;
  logic            valid_o;
  logic            ready_i;
  logic [BITS-1:0] d_o;
  logic            bout_o;
  logic            zero_o;
  logic            ovf_o;

  // Environment side: issues operands and consumes results.
  modport master (
    output valid_i, a_i, b_i, bin_i, ready_i,
    input  ready_o, valid_o, d_o, bout_o, zero_o, ovf_o
  );

  // Subtractor side.
  modport slave (
    input  valid_i, a_i, b_i, bin_i, ready_i,
    output ready_o, valid_o, d_o, bout_o, zero_o, ovf_o
  );
endinterface

// File: rtl/vec_sub_pipe.sv
// Two-stage pipelined subtractor D = A - B - bin with borrow-out, zero and signed-overflow flags.
// Latency 2 cycles from input handshake to valid_o; throughput 1 op/cycle.
// Holds at most 2 ops; ready_o drops only when both stages are full and the consumer stalls.
module vec_sub_pipe #(
  parameter int BITS  = 48,
  parameter int SPLIT = 24
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  vec_sub_pipe_if.slave bus
);

  localparam int NBLK = BITS / 4;
  localparam int SBLK = SPLIT / 4;
  localparam int HI   = BITS - SPLIT;

  // Stage 1: low result half plus everything the upper half still needs.
  logic            s1_valid;
  logic [SPLIT-1:0] s1_lo;
  logic            s1_c;
  logic [HI-1:0]   s1_ahi;
  logic [HI-1:0]   s1_nbhi;
  logic            s1_amsb;
  logic            s1_bmsb;

  // Stage 2: final result and flags, driven straight to the outputs.
  logic            s2_valid;
  logic [BITS-1:0] s2_d;
  logic            s2_bout;
  logic            s2_zero;
  logic            s2_ovf;

  logic s2_free;
  logic s1_adv;
  logic in_hs;

  assign s2_free     = !s2_valid || bus.ready_i;
  assign s1_adv      = s1_valid && s2_free;
  assign bus.ready_o = !s1_valid || s2_free;
  assign in_hs       = bus.valid_i && bus.ready_o;

  // One shared lookahead adder: the low blocks see the live operands (A + ~B + ~bin),
  // the high blocks see the stage-1 fields with the registered split carry.
  logic [BITS-1:0] add_x;
  logic [BITS-1:0] add_y;
  logic [BITS-1:0] add_sum;
  logic [NBLK-1:0] blk_g;
  logic [NBLK-1:0] blk_p;
  logic [NBLK-1:0] blk_cin;
  logic            lo_cout;
  logic            hi_cout;

  assign add_x = {s1_ahi, bus.a_i[SPLIT-1:0]};
  assign add_y = {s1_nbhi, ~bus.b_i[SPLIT-1:0]};

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign x = add_x[4*k +: 4];
    assign y = add_y[4*k +: 4];
    assign g = x & y;
    assign p = x ^ y;

    // In-block lookahead: every carry is a flat function of g/p and the block carry-in.
    assign c[0] = blk_cin[k];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);

    assign blk_g[k] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign blk_p[k] = &p;

    assign add_sum[4*k +: 4] = p ^ c;
  end

  // Block-level carry chain from group generate/propagate; the chain restarts at the
  // split with the carry captured in stage 1.
  always_comb begin
    logic c;
    blk_cin = '0;
    lo_cout = 1'b0;
    c       = ~bus.bin_i;
    for (int k = 0; k < NBLK; k++) begin
      if (k == SBLK) begin
        lo_cout = c;
        c       = s1_c;
      end
      blk_cin[k] = c;
      c          = blk_g[k] | (blk_p[k] & c);
    end
    hi_cout = c;
  end

  logic [BITS-1:0] d_next;
  logic            bout_next;
  logic            zero_next;
  logic            ovf_next;

  assign d_next    = {add_sum[BITS-1:SPLIT], s1_lo};
  assign bout_next = ~hi_cout;
  assign zero_next = (d_next == '0);
  assign ovf_next  = (s1_amsb != s1_bmsb) && (d_next[BITS-1] != s1_amsb);

  // Stage occupancy: S1 fills on accept and empties on advance; S2 fills on advance
  // and empties when the consumer takes it with nothing behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_hs) begin
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid <= 1'b1;
      end else if (bus.ready_i) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Stage-1 data capture, only on an accepted op.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_lo   <= '0;
      s1_c    <= 1'b0;
      s1_ahi  <= '0;
      s1_nbhi <= '0;
      s1_amsb <= 1'b0;
      s1_bmsb <= 1'b0;
    end else if (in_hs) begin
      s1_lo   <= add_sum[SPLIT-1:0];
      s1_c    <= lo_cout;
      s1_ahi  <= bus.a_i[BITS-1:SPLIT];
      s1_nbhi <= ~bus.b_i[BITS-1:SPLIT];
      s1_amsb <= bus.a_i[BITS-1];
      s1_bmsb <= bus.b_i[BITS-1];
    end
  end

  // Stage-2 data capture, only when S1 advances; otherwise results hold for the consumer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_d    <= '0;
      s2_bout <= 1'b0;
      s2_zero <= 1'b0;
      s2_ovf  <= 1'b0;
    end else if (s1_adv) begin
      s2_d    <= d_next;
      s2_bout <= bout_next;
      s2_zero <= zero_next;
      s2_ovf  <= ovf_next;
    end
  end

  assign bus.valid_o = s2_valid;
  assign bus.d_o     = s2_d;
  assign bus.bout_o  = s2_bout;
  assign bus.zero_o  = s2_zero;
  assign bus.ovf_o   = s2_ovf;

endmodule

// File: tb/tb_vec_sub_pipe.sv
// Self-checking bench for vec_sub_pipe: directed corner cases, stall/back-pressure,
// randomized streaming against an arithmetic reference model, and mid-flight reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_vec_sub_pipe;

  typedef struct packed {
    logic [47:0] d;
    logic        bout;
    logic        zero;
    logic        ovf;
  } res_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  vec_sub_pipe_if #(.BITS(48)) bus ();

  vec_sub_pipe #(.BITS(48), .SPLIT(24)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction; borrow is a negative unsigned difference,
  // overflow is a signed difference outside the 48-bit signed range.
  function automatic res_t model(input logic [47:0] a, input logic [47:0] b, input logic bin);
    res_t        r;
    longint      ud;
    longint      sd;
    logic [63:0] dv;
    ud     = longint'(a) - longint'(b) - longint'(bin);
    dv     = ud;
    r.d    = dv[47:0];
    r.bout = (ud < 0);
    r.zero = (r.d == 48'd0);
    sd     = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    r.ovf  = (sd > 64'sd140737488355327) || (sd < -64'sd140737488355328);
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0];
  endfunction

  function automatic res_t observed();
    res_t r;
    r.d    = bus.d_o;
    r.bout = bus.bout_o;
    r.zero = bus.zero_o;
    r.ovf  = bus.ovf_o;
    return r;
  endfunction

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.bin_i   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_o: got %b want 0", bus.valid_o); end
    n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_o: got %b want 1", bus.ready_o); end
    n_checks++; if (bus.d_o !== 48'd0) begin n_fail++; $display("FAIL reset_d_o: got %h want 0", bus.d_o); end
    n_checks++; if (bus.bout_o !== 1'b0) begin n_fail++; $display("FAIL reset_bout_o: got %b want 0", bus.bout_o); end
    n_checks++; if (bus.zero_o !== 1'b0) begin n_fail++; $display("FAIL reset_zero_o: got %b want 0", bus.zero_o); end
    n_checks++; if (bus.ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_o: got %b want 0", bus.ovf_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [47:0] ta [5];
    logic [47:0] tb_b [5];
    logic        tbin [5];
    res_t        texp [5];
    res_t        got;
    ta[0] = 48'h0;            tb_b[0] = 48'h1; tbin[0] = 1'b0; texp[0] = '{48'hFFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    ta[1] = 48'h0000_0100_0000; tb_b[1] = 48'h1; tbin[1] = 1'b0; texp[1] = '{48'h0000_00FF_FFFF, 1'b0, 1'b0, 1'b0};
    ta[2] = 48'h5;            tb_b[2] = 48'h5; tbin[2] = 1'b0; texp[2] = '{48'h0, 1'b0, 1'b1, 1'b0};
    ta[3] = 48'h8000_0000_0000; tb_b[3] = 48'h1; tbin[3] = 1'b0; texp[3] = '{48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
    ta[4] = 48'h3;            tb_b[4] = 48'h2; tbin[4] = 1'b1; texp[4] = '{48'h0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.a_i     = ta[i];
      bus.b_i     = tb_b[i];
      bus.bin_i   = tbin[i];
      bus.ready_i = 1'b1;
      #1;
      n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL directed[%0d]_accept: ready_o got %b want 1", i, bus.ready_o); end
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL directed[%0d]_early: valid_o got %b want 0 one cycle after accept", i, bus.valid_o); end
      @(negedge clk);
      #1;
      got = observed();
      n_checks++; if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL directed[%0d]_latency: valid_o got %b want 1 two cycles after accept", i, bus.valid_o); end
      n_checks++; if (got !== texp[i]) begin n_fail++; $display("FAIL directed[%0d]_result: got d=%h bo=%b z=%b ov=%b want d=%h bo=%b z=%b ov=%b", i, got.d, got.bout, got.zero, got.ovf, texp[i].d, texp[i].bout, texp[i].zero, texp[i].ovf); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [47:0] oa [6];
    logic [47:0] ob [6];
    logic        obin [6];
    res_t        q [$];
    res_t        exp_r;
    res_t        got;
    int          idx;
    int          nget;
    logic        prev_stall;
    logic [47:0] prev_d;
    logic        saw_drop;
    for (int i = 0; i < 6; i++) begin
      oa[i] = rand48(); ob[i] = rand48(); obin[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; nget = 0; prev_stall = 1'b0; prev_d = '0; saw_drop = 1'b0;
    for (int c = 0; c < 60 && nget < 6; c++) begin
      @(negedge clk);
      bus.valid_i = (idx < 6);
      if (idx < 6) begin
        bus.a_i = oa[idx]; bus.b_i = ob[idx]; bus.bin_i = obin[idx];
      end
      bus.ready_i = !(c >= 2 && c <= 5);
      #1;
      n_checks++; if (bus.ready_o !== ((q.size() < 2) || bus.ready_i)) begin n_fail++; $display("FAIL b2b_ready_o[c%0d]: got %b want %b with %0d in flight", c, bus.ready_o, ((q.size() < 2) || bus.ready_i), q.size()); end
      if (!bus.ready_o) saw_drop = 1'b1;
      if (prev_stall && bus.valid_o) begin
        n_checks++; if (bus.d_o !== prev_d) begin n_fail++; $display("FAIL b2b_stall_hold[c%0d]: d_o got %h want %h", c, bus.d_o, prev_d); end
      end
      if (bus.valid_o && bus.ready_i) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_result[c%0d]: got d=%h want no result", c, bus.d_o);
        end else begin
          exp_r = q.pop_front();
          got   = observed();
          if (got !== exp_r) begin n_fail++; $display("FAIL b2b_result[%0d]: got d=%h bo=%b z=%b ov=%b want d=%h bo=%b z=%b ov=%b", nget, got.d, got.bout, got.zero, got.ovf, exp_r.d, exp_r.bout, exp_r.zero, exp_r.ovf); end
          nget++;
        end
      end
      if (bus.valid_i && bus.ready_o) begin
        q.push_back(model(oa[idx], ob[idx], obin[idx]));
        idx++;
      end
      prev_stall = bus.valid_o && !bus.ready_i;
      prev_d     = bus.d_o;
    end
    n_checks++; if (nget !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d results want 6 within cycle budget", nget); end
    n_checks++; if (saw_drop !== 1'b1) begin n_fail++; $display("FAIL b2b_refuse: ready_o never dropped, got %b want 1", saw_drop); end
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    #1;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_duplicate: valid_o got %b want 0 after all results", bus.valid_o); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [47:0] sa [100];
    logic [47:0] sb [100];
    logic        sbin [100];
    res_t        exp_r;
    res_t        got;
    int unsigned mode;
    for (int i = 0; i < 100; i++) begin
      mode    = $urandom_range(0, 7);
      sa[i]   = rand48();
      sb[i]   = rand48();
      sbin[i] = 1'($urandom_range(0, 1));
      if (mode == 0) sb[i] = sa[i];
      if (mode == 1) sa[i] = 48'd0;
      if (mode == 2) begin sa[i][47] = 1'b1; sb[i] = 48'($urandom_range(0, 3)); end
      if (mode == 3) begin sa[i][47] = 1'b0; sb[i][47] = 1'b1; end
    end
    for (int c = 0; c < 102; c++) begin
      @(negedge clk);
      bus.valid_i = (c < 100);
      if (c < 100) begin
        bus.a_i = sa[c]; bus.b_i = sb[c]; bus.bin_i = sbin[c];
      end
      bus.ready_i = 1'b1;
      #1;
      if (c < 100) begin
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL stream_ready_o[c%0d]: got %b want 1", c, bus.ready_o); end
      end
      n_checks++; if (bus.valid_o !== (c >= 2)) begin n_fail++; $display("FAIL stream_valid_o[c%0d]: got %b want %b", c, bus.valid_o, (c >= 2)); end
      if (c >= 2) begin
        exp_r = model(sa[c-2], sb[c-2], sbin[c-2]);
        got   = observed();
        n_checks++; if (got !== exp_r) begin n_fail++; $display("FAIL stream_result[%0d]: got d=%h bo=%b z=%b ov=%b want d=%h bo=%b z=%b ov=%b", c-2, got.d, got.bout, got.zero, got.ovf, exp_r.d, exp_r.bout, exp_r.zero, exp_r.ovf); end
      end
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  task automatic test_reset_midflight();
    res_t        exp_r;
    res_t        got;
    logic [47:0] a;
    logic [47:0] b;
    @(negedge clk);
    bus.valid_i = 1'b1; bus.a_i = rand48(); bus.b_i = rand48(); bus.bin_i = 1'b0; bus.ready_i = 1'b0;
    @(negedge clk);
    bus.a_i = rand48(); bus.b_i = rand48(); bus.bin_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    #1;
    n_checks++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_full_ready_o: got %b want 0 with 2 in flight", bus.ready_o); end
    n_checks++; if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_full_valid_o: got %b want 1", bus.valid_o); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid_o: got %b want 0", bus.valid_o); end
    n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_async_ready_o: got %b want 1", bus.ready_o); end
    n_checks++; if (bus.d_o !== 48'd0) begin n_fail++; $display("FAIL rst_async_d_o: got %h want 0", bus.d_o); end
    @(negedge clk);
    rst_n       = 1'b1;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_stale[%0d]: valid_o got %b want 0", i, bus.valid_o); end
    end
    a = rand48();
    b = rand48();
    exp_r = model(a, b, 1'b1);
    @(negedge clk);
    bus.valid_i = 1'b1; bus.a_i = a; bus.b_i = b; bus.bin_i = 1'b1;
    #1;
    n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_next_accept: ready_o got %b want 1", bus.ready_o); end
    @(negedge clk);
    bus.valid_i = 1'b0;
    #1;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_next_early: valid_o got %b want 0", bus.valid_o); end
    @(negedge clk);
    #1;
    got = observed();
    n_checks++; if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_next_latency: valid_o got %b want 1", bus.valid_o); end
    n_checks++; if (got !== exp_r) begin n_fail++; $display("FAIL rst_next_result: got d=%h bo=%b z=%b ov=%b want d=%h bo=%b z=%b ov=%b", got.d, got.bout, got.zero, got.ovf, exp_r.d, exp_r.bout, exp_r.zero, exp_r.ovf); end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stream();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_sub_pipe.md
Name: vec_sub_pipe

Overview:
- Two-stage pipelined BITS-wide subtractor for the vector unit: D = A - B - bin, with borrow-out, zero and signed-overflow flags.
- Complement path to the unit's carry-lookahead adder: uses the same 4-bit-block lookahead structure on A + ~B + ~bin.
- Sits between operand issue and vector writeback.
- Valid/ready on both sides, throughput 1 op/cycle.

Parameters:
- BITS, 48, operand and result width; multiple of 4.
- SPLIT, 24, number of bits resolved in stage 1; multiple of 4, 0 < SPLIT < BITS.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- valid_i  in  1  input operands valid.
- ready_o  out  1  block accepts operands this cycle.
- a_i  in  BITS  minuend.
- b_i  in  BITS  subtrahend.
- bin_i  in  1  borrow-in.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- d_o  out  BITS  difference, modulo 2^BITS.
- bout_o  out  1  borrow-out; 1 when the unsigned A < B + bin.
- zero_o  out  1  d_o == 0.
- ovf_o  out  1  signed overflow.

Behaviour:
- Arithmetic:
  - Sum = A + ~B + carry-in, with carry-in = ~bin_i.
  - bout_o = ~carry-out of bit BITS-1.
  - ovf_o = (a[BITS-1] != b[BITS-1]) && (d[BITS-1] != a[BITS-1]).
- Stage 1 (S1) register, loaded on input handshake (valid_i && ready_o):
  - low SPLIT result bits and the carry out of bit SPLIT-1;
  - a_i[BITS-1:SPLIT], ~b_i[BITS-1:SPLIT], a/b MSBs;
  - s1_valid.
- Stage 2 (S2) register: full d, bout, zero, ovf, s2_valid. Upper bits are computed from the S1 fields with the registered carry as carry-in.
- Advance rules:
  - s2_free = !s2_valid || ready_i.
  - S1 moves to S2 when s1_valid && s2_free.
  - s2_valid clears when ready_i && !(s1_valid).
  - ready_o = !s1_valid || s2_free; combinational, no dependence on valid_i.
- Latency: an accepted op appears on valid_o 2 cycles later when there is no back-pressure.
- Outputs come directly from the S2 registers.
- Back-pressure:
  - While valid_o && !ready_i, d_o and all flags hold stable.
  - Maximum 2 ops in flight; the third is refused via ready_o = 0.
  - No op is dropped or duplicated.
- Simultaneous events: an S2 drain, an S1 to S2 move and a new S1 load in the same cycle are legal and sustain 1 op/cycle.
- Reset (async assert, sync-safe deassert by the system):
  - s1_valid = s2_valid = 0; all data registers = 0.
  - Hence valid_o = 0, d_o = 0, bout_o = 0, zero_o = 0, ovf_o = 0, ready_o = 1.
  - Reset mid-operation discards all in-flight ops; nothing is emitted after release.
- Data registers load only on their stage's enable and are never updated with invalid data.
- No combinational path from a_i/b_i to any output.

Test Plan:
1. a=0, b=1, bin=0 -> d=48'hFFFF_FFFF_FFFF, bout=1, zero=0, ovf=0, valid_o exactly 2 cycles after accept.
2. a=48'h0000_0100_0000, b=1, bin=0 (borrow crosses the bit-24 split) -> d=48'h0000_00FF_FFFF, bout=0; then a=5, b=5, bin=0 -> d=0, zero=1, bout=0.
3. a=48'h8000_0000_0000, b=1 -> d=48'h7FFF_FFFF_FFFF, ovf=1, bout=0; then a=3, b=2, bin=1 -> d=0, zero=1, bout=0.
4. Stream 6 back-to-back ops with ready_i=0 for cycles 2-5:
   - ready_o drops after 2 ops are in flight;
   - d_o is stable while stalled;
   - all 6 results emerge in order with no loss or duplication.
5. Continuous valid_i=1, ready_i=1 for 100 random ops -> one result per cycle after 2-cycle fill; every result matches a reference model (A-B-bin mod 2^48, flags).
6. Assert rst_ni low with 2 ops in flight and ready_i=0 -> valid_o=0 and ready_o=1 immediately (async); no stale result after release; the next op completes correctly in 2 cycles.
